// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Shared fetch-state encoding, widths and instruction field map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam int c_PC_WIDTH    = 12;
    localparam int c_INSTR_WIDTH = 19;

    // Field positions shared with the Controller's decoder
    localparam int c_OPCODE_MSB  = 18;
    localparam int c_OPCODE_LSB  = 13;
    localparam int c_TARGET_MSB  = 11;
    localparam int c_TARGET_LSB  = 0;
    localparam int c_OFFSET_MSB  = 7;
    localparam int c_OFFSET_LSB  = 0;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// ============================================================================
// Module   : next_pc_logic
// Brief    : Combinational next-PC select (const > offset > plus1) with
//            a not-one-hot select flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_logic #(
    parameter int PC_WIDTH     = 12,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    // Only the operand bits of the held instruction are routed here
    input  logic [PC_WIDTH-1:0] instr,
    input  logic                sel_plus1,
    input  logic                sel_offset,
    input  logic                sel_const,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                sel_err
);

    logic [2:0]          w_sel;
    logic [PC_WIDTH-1:0] w_offset_sext;

    assign w_sel         = {sel_const, sel_offset, sel_plus1};
    assign w_offset_sext = {{(PC_WIDTH-OFFSET_WIDTH){instr[OFFSET_WIDTH-1]}},
                            instr[OFFSET_WIDTH-1:0]};
    assign sel_err       = (w_sel == 3'd0) || ((w_sel & (w_sel - 3'd1)) != 3'd0);

    always_comb begin
        next_pc = pc + PC_WIDTH'(1);
        if (sel_const) begin
            next_pc = instr;
        end else if (sel_offset) begin
            next_pc = pc + w_offset_sext;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner; fetches instructions over req/valid, holds one in the
//            instruction register until accepted, then steps the PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH     = c_PC_WIDTH,
    parameter int INSTR_WIDTH  = c_INSTR_WIDTH,
    parameter int OFFSET_WIDTH = 8,
    parameter int RESET_PC     = 0,
    parameter int TIMEOUT      = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   sel_PCSrc_plus1,
    input  logic                   sel_PCSrc_offset,
    input  logic                   sel_PCSrc_const,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus1,
    output logic                   pc_sel_err,
    output logic                   fetch_retry
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [c_CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                   pc_sel_err_q, pc_sel_err_d;
    logic                   fetch_retry_q, fetch_retry_d;

    logic [PC_WIDTH-1:0]    w_next_pc;
    logic                   w_sel_err;
    logic                   w_req;
    logic                   w_capture;

    next_pc_logic #(
        .PC_WIDTH     (PC_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_next_pc_logic (
        .pc         (pc_q),
        .instr      (instr_q[PC_WIDTH-1:0]),
        .sel_plus1  (sel_PCSrc_plus1),
        .sel_offset (sel_PCSrc_offset),
        .sel_const  (sel_PCSrc_const),
        .next_pc    (w_next_pc),
        .sel_err    (w_sel_err)
    );

    // The retry pulse cycle doubles as the one-cycle request gap
    assign w_req     = !rst && (state_q == FETCH) && !fetch_retry_q;
    assign w_capture = w_req && imem_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        tmo_cnt_d     = tmo_cnt_q;
        pc_sel_err_d  = 1'b0;
        fetch_retry_d = 1'b0;
        case (state_q)
            FETCH: begin
                if (w_capture) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    tmo_cnt_d     = '0;
                    state_d       = HOLD;
                end else if (w_req) begin
                    if (tmo_cnt_q == c_CNT_W'(TIMEOUT - 1)) begin
                        tmo_cnt_d     = '0;
                        fetch_retry_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d          = w_next_pc;
                    instr_valid_d = 1'b0;
                    pc_sel_err_d  = w_sel_err;
                    state_d       = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= PC_WIDTH'(RESET_PC);
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            tmo_cnt_q     <= '0;
            pc_sel_err_q  <= 1'b0;
            fetch_retry_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            tmo_cnt_q     <= tmo_cnt_d;
            pc_sel_err_q  <= pc_sel_err_d;
            fetch_retry_q <= fetch_retry_d;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus1    = pc_q + PC_WIDTH'(1);
    assign pc_sel_err  = pc_sel_err_q;
    assign fetch_retry = fetch_retry_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed and randomized bench for instruction_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    localparam int c_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [18:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [18:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        sel_plus1 = 1'b0;
    logic        sel_offset = 1'b0;
    logic        sel_const = 1'b0;
    logic [11:0] pc;
    logic [11:0] pc_plus1;
    logic        pc_sel_err;
    logic        fetch_retry;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_pc;
    logic [18:0] m_instr;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .PC_WIDTH     (12),
        .INSTR_WIDTH  (19),
        .OFFSET_WIDTH (8),
        .RESET_PC     (0),
        .TIMEOUT      (c_TIMEOUT)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_valid       (imem_valid),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .sel_PCSrc_plus1  (sel_plus1),
        .sel_PCSrc_offset (sel_offset),
        .sel_PCSrc_const  (sel_const),
        .pc               (pc),
        .pc_plus1         (pc_plus1),
        .pc_sel_err       (pc_sel_err),
        .fetch_retry      (fetch_retry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program-level model: where the PC goes after accepting an instruction
    function automatic int model_next(input int cur, input logic [18:0] ins, input logic [2:0] sel);
        int off;
        if (sel[2]) return int'(ins[11:0]);
        if (sel[1]) begin
            off = int'(ins[7:0]);
            if (off >= 128) off = off - 256;
            return (cur + off + 4096) % 4096;
        end
        return (cur + 1) % 4096;
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_valid = 1'b0; instr_ready = 1'b0;
        #1;
        check("req_during_rst", imem_req, 1'b0);
        step();
        imem_valid = 1'b1; imem_rdata = 19'h55555;
        #1;
        check("req_during_rst2", imem_req, 1'b0);
        check("rst_pc", pc, 12'h000);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 19'h0);
        check("rst_retry", fetch_retry, 1'b0);
        check("rst_sel_err", pc_sel_err, 1'b0);
        step();
        rst = 1'b0; imem_valid = 1'b0;
        m_pc = 0;
        #1;
        check("req_after_rst", imem_req, 1'b1);
        check("addr_after_rst", imem_addr, 12'h000);
    endtask

    // Memory answers after 'silent' unanswered request cycles
    task automatic fetch(input int silent, input logic [18:0] word);
        int run = 0;
        for (int i = 0; i < silent; i++) begin
            imem_valid = 1'b0; imem_rdata = 19'($urandom);
            instr_ready = 1'($urandom); {sel_const, sel_offset, sel_plus1} = 3'($urandom);
            #1;
            check("req_wait", imem_req, 1'b1);
            check("addr_wait", imem_addr, m_pc);
            step();
            check("sel_err_clear", pc_sel_err, 1'b0);
            run++;
            if (run == c_TIMEOUT) begin
                run = 0;
                #1;
                check("retry_pulse", fetch_retry, 1'b1);
                check("req_gap", imem_req, 1'b0);
                step();
            end else begin
                check("no_retry", fetch_retry, 1'b0);
            end
        end
        imem_valid = 1'b1; imem_rdata = word; instr_ready = 1'($urandom);
        #1;
        check("req_valid", imem_req, 1'b1);
        check("addr_valid", imem_addr, m_pc);
        step();
        imem_valid = 1'b0; instr_ready = 1'b0;
        m_instr = word;
        #1;
        check("instr_valid_set", instr_valid, 1'b1);
        check("instr_captured", instr, m_instr);
        check("pc_of_instr", pc, m_pc);
        check("retry_on_capture", fetch_retry, 1'b0);
        check("req_in_hold", imem_req, 1'b0);
        check("sel_err_clear2", pc_sel_err, 1'b0);
    endtask

    task automatic hold(input int waits, input logic [2:0] sel, input bit spur);
        bit exp_err;
        for (int i = 0; i < waits; i++) begin
            instr_ready = 1'b0;
            imem_valid = spur ? 1'b1 : 1'($urandom);
            imem_rdata = 19'h7FFFF;
            {sel_const, sel_offset, sel_plus1} = 3'($urandom);
            #1;
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr, m_instr);
            check("hold_pc", pc, m_pc);
            check("hold_pc_plus1", pc_plus1, (m_pc + 1) % 4096);
            check("hold_req", imem_req, 1'b0);
            step();
        end
        instr_ready = 1'b1; imem_valid = 1'b0;
        {sel_const, sel_offset, sel_plus1} = sel;
        #1;
        check("accept_valid", instr_valid, 1'b1);
        step();
        exp_err = ($countones(sel) != 1);
        m_pc = model_next(m_pc, m_instr, sel);
        instr_ready = 1'b0; {sel_const, sel_offset, sel_plus1} = 3'b000;
        #1;
        check("sel_err", pc_sel_err, exp_err);
        check("valid_cleared", instr_valid, 1'b0);
        check("next_pc", pc, m_pc);
        check("next_req", imem_req, 1'b1);
        check("next_addr", imem_addr, m_pc);
    endtask

    initial begin
        m_pc = 0;
        m_instr = '0;
        do_reset();

        // zero-latency fetch then step by one
        fetch(0, 19'h1A2B3);
        hold(0, 3'b001, 1'b0);
        fetch(1, 19'h00011);
        hold(1, 3'b001, 1'b0);

        // backward branch from 0x002 wraps to 0xFFE, then plus1 wraps to 0
        fetch(2, 19'h123FC);
        hold(0, 3'b010, 1'b0);
        fetch(0, 19'h00000);
        hold(0, 3'b001, 1'b0);
        fetch(0, 19'h00000);
        hold(0, 3'b001, 1'b0);

        // jump with two selects, then no selects
        fetch(0, 19'h0B3C5);
        hold(0, 3'b101, 1'b0);
        fetch(3, 19'h40000);
        hold(0, 3'b000, 1'b0);

        // timeout with retry, then valid on the 15th cycle exactly
        fetch(c_TIMEOUT, 19'h2AAAA);
        hold(5, 3'b001, 1'b1);
        fetch(c_TIMEOUT - 1, 19'h15555);
        hold(2, 3'b001, 1'b0);
        fetch(2 * c_TIMEOUT + 3, 19'h00040);
        hold(1, 3'b100, 1'b0);

        // reset while fetching at 0x040
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b0;
            #1;
            check("pre_rst_addr", imem_addr, 12'h040);
            step();
        end
        do_reset();
        fetch(0, 19'h0ABCD);
        hold(0, 3'b001, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int silent;
            silent = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 32) : $urandom_range(0, 3);
            fetch(silent, 19'($urandom));
            hold($urandom_range(0, 3), 3'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
